// File: rtl/traffic_checker_pkg.sv
// Shared types and constants for the AXI-Stream counter-sequence checker.
// Holds the FSM state encoding, counter widths and parameter defaults.
package traffic_checker_pkg;

  localparam int CNT_W = 32;
  localparam int ERR_W = 16;

  localparam int DEF_TRANSFER_LENGTH = 256;
  localparam int DEF_THROTTLE_PERIOD = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    CHECK
  } state_e;

endpackage

// File: rtl/traffic_checker_if.sv
// AXI-Stream style beat bundle between a counter source and the checker.
// The master drives data/valid/last; the slave returns ready.
interface traffic_checker_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/traffic_checker_sat_counter.sv
// Up-counter that sticks at all-ones; clear wins over increment.
// Used for every statistics counter in the checker.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_checker.sv
// Checks an incrementing 32-bit counter stream for gaps and tlast placement.
// Ready is registered and optionally throttled one cycle per period.
module traffic_checker
  import traffic_checker_pkg::*;
#(
  parameter int TRANSFER_LENGTH = DEF_TRANSFER_LENGTH,
  parameter int THROTTLE_PERIOD = DEF_THROTTLE_PERIOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             throttle_en,
  input  logic             clear,
  traffic_checker_if.slave axis,
  output logic [CNT_W-1:0] beat_count,
  output logic [CNT_W-1:0] gap_count,
  output logic [CNT_W-1:0] max_gap,
  output logic [ERR_W-1:0] last_error_count,
  output logic             error
);

  localparam logic [7:0] LAST_IDX =
    8'(TRANSFER_LENGTH - 1);
  localparam bit THR_OK = THROTTLE_PERIOD > 0;
  localparam logic [31:0] PH_LAST = THR_OK ?
    32'(THROTTLE_PERIOD - 1) : 32'd0;

  state_e      st_q, st_d;
  logic [31:0] ph_q, ph_d;
  logic        rdy_q, rdy_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] max_q, max_d;

  logic        accept;
  logic        take;
  logic        gap_hit;
  logic        last_bad;
  logic [31:0] diff;

  assign accept   = axis.tvalid && rdy_q;
  assign take     = accept && !clear;
  assign diff     = axis.tdata - exp_q;
  assign gap_hit  = take && (st_q == CHECK) &&
                    (axis.tdata != exp_q);
  assign last_bad = axis.tlast !=
                    (axis.tdata[7:0] == LAST_IDX);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    st_d = SEED;
      SEED:    if (take) st_d = CHECK;
      CHECK:   if (clear) st_d = SEED;
      default: st_d = IDLE;
    endcase
    if (!enable)
      st_d = IDLE;
  end

  // Phase restarts whenever SEED is (re)entered, including via clear.
  always_comb begin
    ph_d = '0;
    if (st_d != IDLE && !(st_d == SEED && st_q != SEED))
      ph_d = (ph_q >= PH_LAST) ? '0 : ph_q + 1'b1;
    rdy_d = (st_d != IDLE) &&
            !(throttle_en && THR_OK && ph_d == PH_LAST);
  end

  always_comb begin
    exp_d = exp_q;
    max_d = max_q;
    if (take)
      exp_d = axis.tdata + 1'b1;
    if (clear)
      max_d = '0;
    else if (gap_hit && diff > max_q)
      max_d = diff;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= IDLE;
      ph_q  <= '0;
      rdy_q <= 1'b0;
      exp_q <= '0;
      max_q <= '0;
    end else begin
      st_q  <= st_d;
      ph_q  <= ph_d;
      rdy_q <= rdy_d;
      exp_q <= exp_d;
      max_q <= max_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_beat (
    .clk   (clk),
    .reset (reset),
    .inc_i (take),
    .clr_i (clear),
    .cnt_o (beat_count)
  );

  sat_counter #(.W(CNT_W)) u_gap (
    .clk   (clk),
    .reset (reset),
    .inc_i (gap_hit),
    .clr_i (clear),
    .cnt_o (gap_count)
  );

  sat_counter #(.W(ERR_W)) u_last (
    .clk   (clk),
    .reset (reset),
    .inc_i (take && last_bad),
    .clr_i (clear),
    .cnt_o (last_error_count)
  );

  assign axis.tready = rdy_q;
  assign max_gap     = max_q;
  assign error       = (|gap_count) ||
                       (|last_error_count);

endmodule

// File: tb/tb_traffic_checker.sv
// Directed bench for traffic_checker with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_traffic_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        throttle_en = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] beat_count;
  logic [31:0] gap_count;
  logic [31:0] max_gap;
  logic [15:0] last_error_count;
  logic        error;

  int nchk = 0;
  int nerr = 0;

  traffic_checker_if axis ();

  traffic_checker dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .throttle_en      (throttle_en),
    .clear            (clear),
    .axis             (axis.slave),
    .beat_count       (beat_count),
    .gap_count        (gap_count),
    .max_gap          (max_gap),
    .last_error_count (last_error_count),
    .error            (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] d,
                      input logic l);
    int n;
    n = 0;
    axis.tdata  = d;
    axis.tvalid = 1'b1;
    axis.tlast  = l;
    while (!axis.tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20)
      check("ready_timeout", 32'(axis.tready), 32'd1);
    @(negedge clk);
    axis.tvalid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int lows;
    logic [31:0] v;
    axis.tdata  = '0;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(axis.tready), 32'd0);
    check("rst_beat", beat_count, 32'd0);
    check("rst_gap", gap_count, 32'd0);
    check("rst_max", max_gap, 32'd0);
    check("rst_lerr", 32'(last_error_count), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(axis.tready), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    check("seed_ready", 32'(axis.tready), 32'd1);

    for (int i = 0; i < 512; i++) begin
      v = 32'(i);
      send(v, v[7:0] == 8'hFF);
    end
    check("c512_beat", beat_count, 32'd512);
    check("c512_gap", gap_count, 32'd0);
    check("c512_lerr", 32'(last_error_count), 32'd0);
    check("c512_error", 32'(error), 32'd0);

    pulse_clear();
    check("clr_beat", beat_count, 32'd0);
    send(32'd100, 1'b0);
    send(32'd101, 1'b0);
    send(32'd102, 1'b0);
    send(32'd105, 1'b0);
    send(32'd106, 1'b0);
    check("gap_cnt", gap_count, 32'd1);
    check("gap_max", max_gap, 32'd2);
    check("gap_beat", beat_count, 32'd5);
    check("gap_error", 32'(error), 32'd1);

    pulse_clear();
    check("clr_error", 32'(error), 32'd0);
    send(32'hFFFF_FFFE, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    send(32'h0000_0000, 1'b0);
    check("wrap_gap", gap_count, 32'd0);
    check("wrap_beat", beat_count, 32'd3);
    check("wrap_lerr", 32'(last_error_count), 32'd0);

    pulse_clear();
    send(32'd10, 1'b1);
    send(32'd255, 1'b0);
    check("last_lerr", 32'(last_error_count), 32'd2);
    check("last_gap", gap_count, 32'd1);
    check("last_max", max_gap, 32'd244);

    // Free-running source with throttling; clear restarts the phase.
    v = 32'd1000;
    throttle_en = 1'b1;
    axis.tvalid = 1'b1;
    axis.tlast  = 1'b0;
    axis.tdata  = v;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    lows = 0;
    for (int i = 0; i < 64; i++) begin
      v++;
      axis.tdata = v;
      if (!axis.tready)
        lows++;
      @(negedge clk);
    end
    axis.tvalid = 1'b0;
    throttle_en = 1'b0;
    check("thr_lows", 32'(lows), 32'd8);
    check("thr_gap", gap_count, 32'd7);
    check("thr_max", max_gap, 32'd1);
    check("thr_beat", beat_count, 32'd56);

    @(negedge clk);
    pulse_clear();
    send(32'd0, 1'b0);
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    check("pre_beat", beat_count, 32'd3);
    check("cc_ready", 32'(axis.tready), 32'd1);
    axis.tdata  = 32'd3;
    axis.tvalid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    axis.tvalid = 1'b0;
    check("cc_beat", beat_count, 32'd0);
    check("cc_gap", gap_count, 32'd0);
    check("cc_lerr", 32'(last_error_count), 32'd0);
    send(32'd50, 1'b0);
    send(32'd51, 1'b0);
    check("cc_seed_gap", gap_count, 32'd0);
    check("cc_seed_beat", beat_count, 32'd2);

    enable = 1'b0;
    @(negedge clk);
    check("dis_ready", 32'(axis.tready), 32'd0);
    check("dis_hold", beat_count, 32'd2);
    enable = 1'b1;
    @(negedge clk);

    #2 reset = 1'b1;
    #1;
    check("arst_ready", 32'(axis.tready), 32'd0);
    check("arst_beat", beat_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(32'd200, 1'b0);
    send(32'd201, 1'b0);
    check("post_gap", gap_count, 32'd0);
    check("post_beat", beat_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/traffic_checker.md
TRAFFIC_CHECKER -- requirements
Module: traffic_checker

Interface
REQ-001 Parameter TRANSFER_LENGTH, default 256, SHALL set the beat index (tdata[7:0] == TRANSFER_LENGTH-1) at which tlast is expected.
REQ-002 Parameter THROTTLE_PERIOD, default 8, SHALL drop tready for one cycle in every THROTTLE_PERIOD cycles when throttling is on; 0 SHALL disable throttling.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  checker active; low = idle, tready low.
REQ-006 throttle_en  input  1  enables periodic tready deassertion.
REQ-007 clear  input  1  synchronous clear of all statistics.
REQ-008 axis_tdata  input  32  received counter value.
REQ-009 axis_tvalid  input  1  upstream data valid.
REQ-010 axis_tlast  input  1  upstream end-of-transfer marker.
REQ-011 axis_tready  output  1  registered ready to upstream.
REQ-012 beat_count  output  32  accepted beats since clear, saturating.
REQ-013 gap_count  output  32  sequence discontinuities, saturating.
REQ-014 max_gap  output  32  largest observed (tdata - expected), modulo 2^32.
REQ-015 last_error_count  output  16  tlast mismatches, saturating.
REQ-016 error  output  1  high while gap_count or last_error_count is nonzero.

Function
REQ-017 A beat SHALL be accepted in a cycle where axis_tvalid & axis_tready are both high.
REQ-018 FSM SHALL have states IDLE, SEED, CHECK.
REQ-019 IDLE: tready low; enable high -> SEED next cycle.
REQ-020 SEED: first accepted beat loads expected = tdata+1, increments beat_count, performs no gap check; -> CHECK.
REQ-021 CHECK: each accepted beat with tdata != expected SHALL increment gap_count and update max_gap if (tdata - expected) exceeds it; expected SHALL always reload tdata+1 (resync).
REQ-022 Increment arithmetic SHALL be 32-bit modular: 0xFFFFFFFF followed by 0x00000000 is not a gap.
REQ-023 Every accepted beat (SEED or CHECK) SHALL compare axis_tlast against (tdata[7:0] == TRANSFER_LENGTH-1) and increment last_error_count on mismatch.
REQ-024 enable low in any state SHALL return to IDLE next cycle; statistics SHALL be held, not cleared.
REQ-025 axis_tready SHALL be registered: high in SEED/CHECK except the one cycle per THROTTLE_PERIOD when throttle_en is high; throttle phase counter runs only outside IDLE and restarts at 0 on entering SEED.
REQ-026 All statistic outputs SHALL update one cycle after the accepting edge; error SHALL follow counts combinationally from registers.
REQ-027 All counters SHALL saturate at all-ones, never wrap.
REQ-028 clear SHALL zero beat_count, gap_count, max_gap, last_error_count and, if not IDLE, force SEED; clear SHALL take priority over a beat accepted the same cycle (beat discarded from statistics).
REQ-029 Upstream free-running mode (data advancing while tready low) SHALL appear as gaps; no special handling.

Reset
REQ-030 reset SHALL asynchronously force IDLE, axis_tready=0, expected=0, all counts and max_gap=0, throttle phase=0, error=0.
REQ-031 reset deassertion mid-stream SHALL start in IDLE and require SEED before checking.

Structure
REQ-032 Package traffic_checker_pkg SHALL hold the FSM state enumeration, counter width constants (32, 16) and the default TRANSFER_LENGTH/THROTTLE_PERIOD.
REQ-033 A sub-module sat_counter (parameterised width, inc, clear, saturating) SHALL be instantiated for beat_count, gap_count and last_error_count.

Verification
REQ-034 Contiguous 0..511, tlast at 255 and 511, throttle off -> beat_count=512, gap_count=0, last_error_count=0, error=0.
REQ-035 Seed 100, then 101,102,105,106 -> gap_count=1, max_gap=2, beat_count=5, error=1.
REQ-036 Sequence 0xFFFFFFFE,0xFFFFFFFF,0x00000000 -> gap_count=0.
REQ-037 throttle_en=1, THROTTLE_PERIOD=8, upstream freerun counting every cycle for 64 cycles -> tready low 1 cycle in 8, gap_count=7 over 8 periods after first, max_gap=1.
REQ-038 tlast asserted at tdata=10 and missing at 255 -> last_error_count=2.
REQ-039 clear pulse coincident with an accepted beat mid-stream, then reset asserted asynchronously -> counts zero after clear, FSM SEED; reset forces IDLE and tready=0 without waiting for clk.
